// File: rtl/rx_operand_entry.sv
// rx_operand_entry: receive-side operand entry for the calculator.
// Collects decimal keystrokes from the UART receiver into a BCD digit buffer, supports
// backspace and clear, and on Enter converts the buffer digit-serially to an unsigned
// binary operand (saturating at 2^WIDTH-1). Accepted digits and backspaces are echoed
// back through a one-entry pending register when the transmitter is busy.
//
// Ports:
//   clk            system clock
//   resetn         asynchronous active-low reset
//   uart_rx_valid  one-cycle strobe, uart_rx_data holds a received byte
//   uart_rx_data   received byte
//   echo_busy      transmitter busy
//   echo_en        one-cycle request to transmit echo_data
//   echo_data      byte to echo
//   operand        last converted operand, held until the next conversion
//   operand_valid  one-cycle pulse when operand updates
//   overflow       last operand saturated
//   digit_count    digits currently buffered
module rx_operand_entry #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 5
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              uart_rx_valid,
  input  logic [7:0]                        uart_rx_data,
  input  logic                              echo_busy,
  output logic                              echo_en,
  output logic [7:0]                        echo_data,
  output logic [WIDTH-1:0]                  operand,
  output logic                              operand_valid,
  output logic                              overflow,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned BufW = MAX_DIGITS * 4;
  localparam int unsigned AccW = WIDTH + 4;
  // Extra nibble so acc*10 + 9 never wraps before the saturation test.
  localparam int unsigned MulW = AccW + 4;

  typedef enum logic [1:0] {StEmpty, StEntry, StConvert, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   idx_q, idx_d;
  logic [BufW-1:0]   buf_q, buf_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic              sat_q, sat_d;
  logic [WIDTH-1:0]  operand_q, operand_d;
  logic              operand_valid_q, operand_valid_d;
  logic              overflow_q, overflow_d;
  logic              echo_en_q, echo_en_d;
  logic [7:0]        echo_data_q, echo_data_d;
  logic              pend_q, pend_d;
  logic [7:0]        pend_data_q, pend_data_d;

  logic              is_digit, is_bksp, is_clear, is_enter;
  logic              echo_req;
  logic [7:0]        echo_byte;
  logic [3:0]        cur_digit;
  logic [MulW-1:0]   mul;

  always_comb begin
    is_digit = uart_rx_valid && (uart_rx_data >= 8'h30) && (uart_rx_data <= 8'h39);
    is_bksp  = uart_rx_valid && ((uart_rx_data == 8'h08) || (uart_rx_data == 8'h7F));
    is_clear = uart_rx_valid && (uart_rx_data == 8'h1B);
    is_enter = uart_rx_valid && (uart_rx_data == 8'h0D);
  end

  // Newest digit sits in nibble 0, so the oldest unconsumed digit is nibble idx-1.
  always_comb begin
    cur_digit = 4'h0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (CntW'(i) == idx_q - CntW'(1)) begin
        cur_digit = buf_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    mul = MulW'(acc_q) * MulW'(10) + MulW'(cur_digit);
  end

  // Entry / conversion FSM.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    buf_d           = buf_q;
    acc_d           = acc_q;
    sat_d           = sat_q;
    operand_d       = operand_q;
    operand_valid_d = 1'b0;
    overflow_d      = overflow_q;
    echo_req        = 1'b0;
    echo_byte       = 8'h00;

    unique case (state_q)
      StEmpty: begin
        if (is_digit) begin
          buf_d     = BufW'(uart_rx_data[3:0]);
          cnt_d     = CntW'(1);
          state_d   = StEntry;
          echo_req  = 1'b1;
          echo_byte = uart_rx_data;
        end
      end
      StEntry: begin
        if (is_digit) begin
          if (cnt_q < CntW'(MAX_DIGITS)) begin
            buf_d     = (buf_q << 4) | BufW'(uart_rx_data[3:0]);
            cnt_d     = cnt_q + CntW'(1);
            echo_req  = 1'b1;
            echo_byte = uart_rx_data;
          end
        end else if (is_bksp) begin
          buf_d     = buf_q >> 4;
          cnt_d     = cnt_q - CntW'(1);
          echo_req  = 1'b1;
          echo_byte = 8'h08;
          if (cnt_q == CntW'(1)) begin
            state_d = StEmpty;
          end
        end else if (is_clear) begin
          cnt_d   = '0;
          state_d = StEmpty;
        end else if (is_enter) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          idx_d   = cnt_q;
          state_d = StConvert;
        end
      end
      StConvert: begin
        acc_d = mul[AccW-1:0];
        if (|mul[MulW-1:WIDTH]) begin
          sat_d = 1'b1;
        end
        idx_d = idx_q - CntW'(1);
        if (idx_q == CntW'(1)) begin
          // Load the result on the last step so it is visible throughout DONE.
          operand_d       = sat_d ? {WIDTH{1'b1}} : acc_d[WIDTH-1:0];
          overflow_d      = sat_d;
          operand_valid_d = 1'b1;
          state_d         = StDone;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StEmpty;
      end
      default: begin
        state_d = StEmpty;
      end
    endcase
  end

  // Echo path. A request goes straight out only when nothing is in flight or queued;
  // otherwise it lands in the pending slot (overwriting any older byte). echo_en_q is
  // treated as busy so echo_en never stays high for two cycles.
  always_comb begin
    echo_en_d   = 1'b0;
    echo_data_d = echo_data_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    if (echo_req) begin
      if (!echo_busy && !echo_en_q && !pend_q) begin
        echo_en_d   = 1'b1;
        echo_data_d = echo_byte;
      end else begin
        pend_d      = 1'b1;
        pend_data_d = echo_byte;
      end
    end else if (pend_q && !echo_busy && !echo_en_q) begin
      echo_en_d   = 1'b1;
      echo_data_d = pend_data_q;
      pend_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= StEmpty;
      cnt_q           <= '0;
      idx_q           <= '0;
      buf_q           <= '0;
      acc_q           <= '0;
      sat_q           <= 1'b0;
      operand_q       <= '0;
      operand_valid_q <= 1'b0;
      overflow_q      <= 1'b0;
      echo_en_q       <= 1'b0;
      echo_data_q     <= 8'h00;
      pend_q          <= 1'b0;
      pend_data_q     <= 8'h00;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      buf_q           <= buf_d;
      acc_q           <= acc_d;
      sat_q           <= sat_d;
      operand_q       <= operand_d;
      operand_valid_q <= operand_valid_d;
      overflow_q      <= overflow_d;
      echo_en_q       <= echo_en_d;
      echo_data_q     <= echo_data_d;
      pend_q          <= pend_d;
      pend_data_q     <= pend_data_d;
    end
  end

  assign echo_en       = echo_en_q;
  assign echo_data     = echo_data_q;
  assign operand       = operand_q;
  assign operand_valid = operand_valid_q;
  assign overflow      = overflow_q;
  assign digit_count   = cnt_q;

endmodule

// File: tb/tb_rx_operand_entry.sv
// Self-checking bench for rx_operand_entry: expected echoes and operands are queued as
// stimulus is driven and compared by a monitor when the DUT produces them.
module tb_rx_operand_entry;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned MAX_DIGITS = 5;
  localparam int unsigned CntW       = $clog2(MAX_DIGITS + 1);

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              uart_rx_valid = 1'b0;
  logic [7:0]        uart_rx_data = 8'h00;
  logic              echo_busy = 1'b0;
  logic              echo_en;
  logic [7:0]        echo_data;
  logic [WIDTH-1:0]  operand;
  logic              operand_valid;
  logic              overflow;
  logic [CntW-1:0]   digit_count;

  rx_operand_entry #(
    .WIDTH      (WIDTH),
    .MAX_DIGITS (MAX_DIGITS)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .echo_busy     (echo_busy),
    .echo_en       (echo_en),
    .echo_data     (echo_data),
    .operand       (operand),
    .operand_valid (operand_valid),
    .overflow      (overflow),
    .digit_count   (digit_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   echo_q[$];
  logic [WIDTH:0] op_q[$];  // {overflow, operand}
  int echo_pulses = 0;
  int op_pulses = 0;
  logic prev_echo = 1'b0;
  logic prev_op = 1'b0;
  logic [7:0]   exp_e;
  logic [WIDTH:0] exp_o;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (echo_en) begin
      echo_pulses++;
      n_cmp++;
      if (echo_q.size() == 0) begin
        n_err++;
        $display("FAIL echo_unexpected: got echo 0x%02h, expected no echo", echo_data);
      end else begin
        exp_e = echo_q.pop_front();
        if (echo_data !== exp_e) begin
          n_err++;
          $display("FAIL echo_data: got 0x%02h, expected 0x%02h", echo_data, exp_e);
        end
      end
      if (prev_echo) begin
        n_err++;
        $display("FAIL echo_en_width: got 2 consecutive cycles, expected 1");
      end
    end
    if (operand_valid) begin
      op_pulses++;
      n_cmp++;
      if (op_q.size() == 0) begin
        n_err++;
        $display("FAIL operand_unexpected: got operand %0d, expected no pulse", operand);
      end else begin
        exp_o = op_q.pop_front();
        if ({overflow, operand} !== exp_o) begin
          n_err++;
          $display("FAIL operand: got %0d ovf %0b, expected %0d ovf %0b",
                   operand, overflow, exp_o[WIDTH-1:0], exp_o[WIDTH]);
        end
      end
      if (prev_op) begin
        n_err++;
        $display("FAIL operand_valid_width: got 2 consecutive cycles, expected 1");
      end
    end
    prev_echo = echo_en;
    prev_op   = operand_valid;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_digits(input string s);
    for (int i = 0; i < s.len(); i++) begin
      echo_q.push_back(s[i]);
      send_byte(s[i]);
    end
  endtask

  // Enter with n digits buffered; expects the operand pulse n+1 cycles after the edge.
  task automatic enter_expect(input int n, input int unsigned val, input logic ovf);
    int cyc;
    op_q.push_back({ovf, WIDTH'(val)});
    @(negedge clk);
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h0D;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    cyc = 1;
    while (!operand_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!operand_valid || cyc != n + 1) begin
      n_err++;
      $display("FAIL enter_latency: got %0d cycles (valid=%0b), expected %0d", cyc,
               operand_valid, n + 1);
    end
    @(negedge clk);
    n_cmp++;
    if (digit_count !== '0) begin
      n_err++;
      $display("FAIL count_after_done: got %0d, expected 0", digit_count);
    end
  endtask

  task automatic check_queues_empty(input string name);
    n_cmp++;
    if (echo_q.size() != 0 || op_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d echoes / %0d operands outstanding, expected 0 / 0",
               name, echo_q.size(), op_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (operand !== '0 || operand_valid !== 1'b0 || overflow !== 1'b0 || echo_en !== 1'b0 ||
        echo_data !== 8'h00 || digit_count !== '0) begin
      n_err++;
      $display("FAIL %s: got op=%0d v=%0b ovf=%0b en=%0b data=0x%02h cnt=%0d, expected all 0",
               name, operand, operand_valid, overflow, echo_en, echo_data, digit_count);
    end
  endtask

  task automatic test_reset();
    #1;
    check_reset_outputs("reset_values");
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("after_release");
  endtask

  task automatic test_basic();
    send_digits("123");
    n_cmp++;
    if (digit_count !== CntW'(3)) begin
      n_err++;
      $display("FAIL basic_count: got %0d, expected 3", digit_count);
    end
    enter_expect(3, 123, 1'b0);
    check_queues_empty("basic");
  endtask

  task automatic test_overflow();
    send_digits("99999");
    enter_expect(5, 65535, 1'b1);
    send_digits("7");
    enter_expect(1, 7, 1'b0);
    check_queues_empty("overflow");
  endtask

  task automatic test_backspace();
    logic [7:0] seq [6];
    logic [7:0] ech [6];
    int         cnt [6];
    seq = '{8'h34, 8'h35, 8'h36, 8'h37, 8'h7F, 8'h38};
    ech = '{8'h34, 8'h35, 8'h36, 8'h37, 8'h08, 8'h38};
    cnt = '{1, 2, 3, 4, 3, 4};
    for (int i = 0; i < 6; i++) begin
      echo_q.push_back(ech[i]);
      send_byte(seq[i]);
      n_cmp++;
      if (digit_count !== CntW'(cnt[i])) begin
        n_err++;
        $display("FAIL bksp_count[%0d]: got %0d, expected %0d", i, digit_count, cnt[i]);
      end
    end
    enter_expect(4, 4568, 1'b0);
    check_queues_empty("backspace");
  endtask

  task automatic test_max_digits();
    send_digits("12345");
    send_byte(8'h36);  // sixth digit, no echo expected
    n_cmp++;
    if (digit_count !== CntW'(5)) begin
      n_err++;
      $display("FAIL max_count: got %0d, expected 5", digit_count);
    end
    enter_expect(5, 12345, 1'b0);
    check_queues_empty("max_digits");
  endtask

  task automatic test_clear();
    int ops0, ech0;
    ops0 = op_pulses;
    ech0 = echo_pulses;
    send_byte(8'h0D);
    send_digits("12");
    send_byte(8'h1B);
    send_byte(8'h0D);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (op_pulses != ops0 || digit_count !== '0 || echo_pulses - ech0 != 2) begin
      n_err++;
      $display("FAIL clear: got %0d op pulses cnt=%0d echoes=%0d, expected 0 / 0 / 2",
               op_pulses - ops0, digit_count, echo_pulses - ech0);
    end
    check_queues_empty("clear");
  endtask

  task automatic test_echo_busy();
    int early;
    @(negedge clk);
    echo_busy = 1'b1;
    echo_q.push_back(8'h35);
    send_byte(8'h35);
    early = 0;
    for (int i = 0; i < 4; i++) begin
      if (echo_en) early++;
      @(negedge clk);
    end
    n_cmp++;
    if (early != 0 || echo_en !== 1'b0) begin
      n_err++;
      $display("FAIL busy_hold: got %0d echo pulses while busy, expected 0", early);
    end
    echo_busy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (echo_en !== 1'b1 || echo_data !== 8'h35) begin
      n_err++;
      $display("FAIL busy_release: got en=%0b data=0x%02h, expected en=1 data=0x35",
               echo_en, echo_data);
    end
    send_byte(8'h1B);
    check_queues_empty("echo_busy");
  endtask

  task automatic test_reset_convert();
    int ops0;
    send_digits("999");
    @(negedge clk);
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h0D;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("reset_in_convert");
    @(negedge clk);
    resetn = 1'b1;
    ops0 = op_pulses;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (op_pulses != ops0 || operand !== '0) begin
      n_err++;
      $display("FAIL abort_no_pulse: got %0d pulses operand=%0d, expected 0 pulses operand=0",
               op_pulses - ops0, operand);
    end
    check_queues_empty("reset_convert");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backspace();
    test_max_digits();
    test_clear();
    test_echo_busy();
    test_reset_convert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rx_operand_entry.md
# rx_operand_entry

Receive-side companion to the calculator frame transmitter. It consumes bytes from the UART receiver, collects decimal keystrokes into a BCD digit buffer, supports backspace and clear, and converts the buffer sequentially to an unsigned binary operand when Enter arrives. It also produces a one-byte echo stream for the UART transmitter so the operator sees what they typed.

## Interface
Parameters:
- WIDTH, 16, operand width in bits.
- MAX_DIGITS, 5, maximum decimal digits held in the buffer.

Ports:
- clk  in  1  system clock (100 MHz).
- resetn  in  1  asynchronous, active-low reset.
- uart_rx_valid  in  1  one-cycle strobe: uart_rx_data holds a received byte.
- uart_rx_data  in  8  received byte.
- echo_busy  in  1  transmitter busy (uart_tx_busy).
- echo_en  out  1  one-cycle request to transmit echo_data.
- echo_data  out  8  byte to echo.
- operand  out  WIDTH  last converted operand; held until the next conversion.
- operand_valid  out  1  one-cycle pulse when operand updates.
- overflow  out  1  sticky per conversion: last operand saturated.
- digit_count  out  $clog2(MAX_DIGITS+1)  digits currently buffered.

## Operation
- Character classes: digit 0x30–0x39; backspace 0x08 or 0x7F; clear ESC 0x1B; Enter 0x0D. All other bytes are ignored, with no echo.
- The buffer is MAX_DIGITS×4 BCD bits. A new digit shifts in at the least significant position.
- States:
  - EMPTY
    - Digit: store it, count=1, go to ENTRY.
    - Enter, backspace, clear: ignored.
  - ENTRY
    - Digit when count<MAX_DIGITS: append, count+1, echo.
    - Digit when count==MAX_DIGITS: ignored, no echo.
    - Backspace: drop the newest digit, count−1, echo 0x08. If count reaches 0, go to EMPTY.
    - Clear: count=0, go to EMPTY, no echo.
    - Enter: go to CONVERT with acc=0, idx=count.
  - CONVERT
    - Each cycle: acc = acc*10 + oldest unconsumed digit, idx−1.
    - acc is WIDTH+4 bits wide. If acc ever exceeds 2^WIDTH−1, set a saturate flag.
    - When idx reaches 0, go to DONE.
    - uart_rx_valid is ignored in this state; the byte is lost.
  - DONE (one cycle)
    - operand = saturate ? 2^WIDTH−1 : acc[WIDTH−1:0].
    - operand_valid=1, overflow=saturate, count=0.
    - Go to EMPTY. A byte arriving in this cycle is ignored.
- Echo:
  - Echo applies to accepted digits (same byte) and backspace (0x08). Enter produces no echo.
  - If echo_busy=0 when the echo is generated, echo_en pulses for one cycle.
  - Otherwise the echo is held in a one-entry pending register. echo_en pulses in the first cycle echo_busy=0 is seen.
  - A new echo while one is pending overwrites the pending byte.
- Reset values: operand=0, operand_valid=0, overflow=0, echo_en=0, echo_data=0x00, digit_count=0, state=EMPTY, pending clear.
- Asserting resetn mid-conversion aborts the conversion. operand keeps its reset value 0, and there is no operand_valid pulse.

## Timing
- Byte sampled at edge T:
  - digit_count and state update at edge T.
  - echo_en is high in cycle T+1 (after edge T) when echo_busy was 0 at T.
- Enter sampled at edge T with count=n:
  - CONVERT occupies cycles T+1..T+n.
  - DONE, with operand_valid=1 and the new operand, occurs in cycle T+n+1.
  - Total latency is n+1 cycles.
- operand_valid and echo_en are never high for more than one consecutive cycle.
- overflow updates only in DONE.
- The conversion worst case is MAX_DIGITS+1 cycles, far below one byte time at 9600 baud. Bytes are therefore never lost in practice; the loss rule exists for robustness.

## Test plan
- Reset, then send "123", Enter:
  - echo_en fires three times, with 0x31, 0x32, 0x33.
  - operand_valid pulses 4 cycles after Enter, with operand=123 and overflow=0.
- Send "99999", Enter (WIDTH=16):
  - operand=65535, overflow=1.
  - Then send "7", Enter: operand=7, overflow=0.
- Send "4567", backspace 0x7F, "8", Enter:
  - Echo sequence is 34 35 36 37 08 38.
  - operand=4568; digit_count goes 1,2,3,4,3,4, then 0 after DONE.
- Send "123456" with MAX_DIGITS=5:
  - The sixth digit produces no echo and digit_count stays 5.
  - Enter gives operand=12345.
- Send Enter in EMPTY, then "12", ESC, Enter:
  - No operand_valid pulse ever; digit_count=0; only two echoes.
- Hold echo_busy=1, then send "5":
  - echo_en stays 0 while busy is high.
  - echo_en pulses with 0x35 in the first cycle after echo_busy falls.
- Pull resetn low during CONVERT:
  - All outputs return to their reset values asynchronously.
  - No operand_valid pulse after release.
